simd_intadd_pipe: RTL and testbench

- Parametrised, pipelined SIMD integer add/subtract unit for the SMC integer datapath; successor to the fixed 4x32-bit saturating adder.
- Runtime-selectable lane width (8/16/32), add or subtract, independent per-operand signedness, optional saturation, per-lane overflow flags and a sticky overflow status.
- Sits between the operand-fetch stage and the writeback buffer, with valid/ready handshakes on both sides.

---
 rtl/smc_int_pkg.sv | 34 +++
 rtl/simd_lane_addsat.sv | 83 ++++++++
 rtl/simd_intadd_pipe.sv | 111 +++++++++++
 tb/tb_simd_intadd_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_int_pkg.sv
// Shared definitions for the SMC integer datapath.
//   LM_8 / LM_16 / LM_32 : lane_mode encodings (2'b11 is reserved and behaves as LM_32)
//   lane_width()         : lane width in bits for a lane_mode value
//   sat_hi() / sat_lo()  : saturation limits for a lane width and result domain,
//                          returned as 34-bit signed values (w+2 for the widest lane)
package smc_int_pkg;

  localparam logic [1:0] LM_8  = 2'b00;
  localparam logic [1:0] LM_16 = 2'b01;
  localparam logic [1:0] LM_32 = 2'b10;

  function automatic int unsigned lane_width(input logic [1:0] mode);
    case (mode)
      LM_8:    return 8;
      LM_16:   return 16;
      default: return 32;
    endcase
  endfunction

  // Largest representable value: 2^(w-1)-1 when signed, 2^w-1 when unsigned.
  function automatic logic signed [33:0] sat_hi(input int unsigned w, input logic sdom);
    logic signed [33:0] one;
    one = 34'sd1;
    return sdom ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  // Smallest representable value: -2^(w-1) when signed, 0 when unsigned.
  function automatic logic signed [33:0] sat_lo(input int unsigned w, input logic sdom);
    logic signed [33:0] one;
    one = 34'sd1;
    return sdom ? -(one <<< (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/simd_lane_addsat.sv
// One 32-bit slice of the SIMD add/subtract unit (purely combinational).
// Splits into 4x8, 2x16 or 1x32 lanes with no carry between lanes.
//   a_i, b_i           : 32-bit operand slices
//   sign_a_i, sign_b_i : operand signedness (also selects the signed result domain)
//   sub_i              : 0 = a+b, 1 = a-b
//   sat_i              : 1 = saturate, 0 = wrap
//   mode_i             : lane_mode
//   res_o              : 32-bit result slice
//   ovf_o              : per-byte overflow, replicated across the bytes of wider lanes
module simd_lane_addsat
  import smc_int_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sign_a_i,
  input  logic        sign_b_i,
  input  logic        sub_i,
  input  logic        sat_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] res_o,
  output logic [3:0]  ovf_o
);

  // Operates on a w-bit lane held in the low bits of a/b; returns {ovf, result}.
  function automatic logic [32:0] add_lane(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w, input logic sa,
                                           input logic sb, input logic sub, input logic sat);
    logic [33:0]        xa, xb;
    logic signed [33:0] ea, eb, r, hi, lo;
    logic [31:0]        res;
    logic               ovf_hi, ovf_lo;
    // Park the lane at the top, then shift back down to extend to 34 bits.
    xa = {a << (32 - w), 2'b00};
    xb = {b << (32 - w), 2'b00};
    ea = sa ? ($signed(xa) >>> (34 - w)) : $signed(xa >> (34 - w));
    eb = sb ? ($signed(xb) >>> (34 - w)) : $signed(xb >> (34 - w));
    r  = sub ? ea - eb : ea + eb;
    hi = sat_hi(w, sa | sb);
    lo = sat_lo(w, sa | sb);
    ovf_hi = r > hi;
    ovf_lo = r < lo;
    if (sat && ovf_hi) begin
      res = hi[31:0];
    end else if (sat && ovf_lo) begin
      res = lo[31:0];
    end else begin
      res = r[31:0];
    end
    return {ovf_hi | ovf_lo, res};
  endfunction

  logic [32:0] lane_r;

  always_comb begin
    res_o  = '0;
    ovf_o  = '0;
    lane_r = '0;
    case (mode_i)
      LM_8: begin
        for (int i = 0; i < 4; i++) begin
          lane_r = add_lane({24'b0, a_i[8*i +: 8]}, {24'b0, b_i[8*i +: 8]}, lane_width(LM_8),
                            sign_a_i, sign_b_i, sub_i, sat_i);
          res_o[8*i +: 8] = lane_r[7:0];
          ovf_o[i]        = lane_r[32];
        end
      end
      LM_16: begin
        for (int i = 0; i < 2; i++) begin
          lane_r = add_lane({16'b0, a_i[16*i +: 16]}, {16'b0, b_i[16*i +: 16]},
                            lane_width(LM_16), sign_a_i, sign_b_i, sub_i, sat_i);
          res_o[16*i +: 16] = lane_r[15:0];
          ovf_o[2*i +: 2]   = {2{lane_r[32]}};
        end
      end
      default: begin
        lane_r = add_lane(a_i, b_i, lane_width(LM_32), sign_a_i, sign_b_i, sub_i, sat_i);
        res_o  = lane_r[31:0];
        ovf_o  = {4{lane_r[32]}};
      end
    endcase
  end

endmodule

// File: rtl/simd_intadd_pipe.sv
// Two-stage pipelined SIMD integer add/subtract with saturation and overflow status.
// S1 holds the accepted operands/controls; S2 holds the computed dst/ovf.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand beat handshake (src0, src1, sign_s0, sign_s1,
//                          op_sub, sat_en, lane_mode sampled on acceptance)
//   out_valid / out_ready: result beat handshake (dst, ovf)
//   sticky_ovf           : OR of ovf over all consumed results since the last clear
//   sticky_clr           : clears sticky_ovf (a coincident overflowing result wins)
module simd_intadd_pipe
  import smc_int_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NLANE8 = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic              sign_s0,
  input  logic              sign_s1,
  input  logic              op_sub,
  input  logic              sat_en,
  input  logic [1:0]        lane_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dst,
  output logic [NLANE8-1:0] ovf,
  output logic              sticky_ovf,
  input  logic              sticky_clr
);

  localparam int unsigned NSlice = DATA_W / 32;

  logic              s1_valid_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              sign0_q, sign1_q, sub_q, sat_q;
  logic [1:0]        mode_q;

  logic              out_valid_q, sticky_q;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [NLANE8-1:0] ovf_q, ovf_d;

  logic s2_advance, accept, consume;

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !rst && (!s1_valid_q || s2_advance);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid_q && out_ready;

  for (genvar g = 0; g < NSlice; g++) begin : gen_slice
    simd_lane_addsat u_lane (
      .a_i      (a_q[32*g +: 32]),
      .b_i      (b_q[32*g +: 32]),
      .sign_a_i (sign0_q),
      .sign_b_i (sign1_q),
      .sub_i    (sub_q),
      .sat_i    (sat_q),
      .mode_i   (mode_q),
      .res_o    (dst_d[32*g +: 32]),
      .ovf_o    (ovf_d[4*g +: 4])
    );
  end

  // Operand payload needs no reset: it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= src0;
      b_q     <= src1;
      sign0_q <= sign_s0;
      sign1_q <= sign_s1;
      sub_q   <= op_sub;
      sat_q   <= sat_en;
      mode_q  <= lane_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      ovf_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s2_advance) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          dst_q <= dst_d;
          ovf_q <= ovf_d;
        end
      end
      // Set has priority over clear.
      if (consume && |ovf_q) begin
        sticky_q <= 1'b1;
      end else if (sticky_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign dst        = dst_q;
  assign ovf        = ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_simd_intadd_pipe.sv
// Directed bench for simd_intadd_pipe with a result scoreboard and a negedge monitor.
module tb_simd_intadd_pipe;

  localparam int unsigned DW = 128;
  localparam int unsigned NL = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] src0, src1;
  logic          sign_s0, sign_s1, op_sub, sat_en;
  logic [1:0]    lane_mode;
  logic          out_valid, out_ready;
  logic [DW-1:0] dst;
  logic [NL-1:0] ovf;
  logic          sticky_ovf, sticky_clr;

  always #5 clk = ~clk;

  simd_intadd_pipe #(.DATA_W(DW), .NLANE8(NL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src0       (src0),
    .src1       (src1),
    .sign_s0    (sign_s0),
    .sign_s1    (sign_s1),
    .op_sub     (op_sub),
    .sat_en     (sat_en),
    .lane_mode  (lane_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dst        (dst),
    .ovf        (ovf),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NL-1:0] o;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         pat_en   = 1'b0;
  logic [3:0] pat      = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane integer arithmetic on longint values.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic s0, input logic s1, input logic sub,
                                input logic sat, input logic [1:0] m,
                                output logic [DW-1:0] d, output logic [NL-1:0] o);
    int            w;
    longint        span, ua, ub, va, vb, r, hi, lo, v;
    logic [DW-1:0] ta, tb;
    logic [63:0]   vv;
    bit            of;
    w    = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    span = longint'(1) << w;
    d    = '0;
    o    = '0;
    for (int l = 0; l < 128 / w; l++) begin
      ta = a >> (l * w);
      tb = b >> (l * w);
      ua = longint'(ta[31:0]) & (span - 1);
      ub = longint'(tb[31:0]) & (span - 1);
      va = (s0 && ua >= span / 2) ? ua - span : ua;
      vb = (s1 && ub >= span / 2) ? ub - span : ub;
      r  = sub ? va - vb : va + vb;
      if (s0 || s1) begin
        hi = span / 2 - 1;
        lo = -(span / 2);
      end else begin
        hi = span - 1;
        lo = 0;
      end
      of = (r > hi) || (r < lo);
      v  = (sat && r > hi) ? hi : (sat && r < lo) ? lo : r;
      vv = v;
      for (int k = 0; k < w; k++) d[l*w + k] = vv[k];
      for (int k = 0; k < w / 8; k++) o[l*w/8 + k] = of;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pat_en) out_ready = pat[cyc % 4];
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s0,
                      input logic s1, input logic sub, input logic sat, input logic [1:0] m,
                      input logic [DW-1:0] ed, input logic [NL-1:0] eo);
    bit acc = 1'b0;
    int n   = 0;
    src0 = a; src1 = b; sign_s0 = s0; sign_s1 = s1;
    op_sub = sub; sat_en = sat; lane_mode = m;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (acc) q.push_back('{d: ed, o: eo});
    else check("accept_timeout", DW'(acc), DW'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain", DW'(q.size()), DW'(0));
  endtask

  // Monitor: in_ready occupancy rule, stall stability and in-order scoreboard compare.
  initial begin : monitor
    bit            prev_stall = 1'b0;
    logic [DW-1:0] pd;
    logic [NL-1:0] po;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", DW'(in_ready), DW'(!(q.size() == 2 && !out_ready)));
        if (prev_stall) begin
          check("stall_valid", DW'(out_valid), DW'(1));
          check("stall_dst", dst, pd);
          check("stall_ovf", DW'(ovf), DW'(po));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out", DW'(out_valid), DW'(0));
          end else begin
            e = q.pop_front();
            check("dst", dst, e.d);
            check("ovf", DW'(ovf), DW'(e.o));
          end
        end
        prev_stall = out_valid && !out_ready;
        pd = dst;
        po = ovf;
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] ra, rb, ed;
    logic [NL-1:0] eo;
    logic [1:0]    rm;
    logic          rs0, rs1, rsub, rsat;
    int            n;

    rst = 1'b1; in_valid = 1'b0; src0 = '0; src1 = '0;
    sign_s0 = 1'b0; sign_s1 = 1'b0; op_sub = 1'b0; sat_en = 1'b0; lane_mode = 2'b00;
    out_ready = 1'b1; sticky_clr = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_dst", dst, '0);
    check("rst_ovf", DW'(ovf), DW'(0));
    check("rst_sticky", DW'(sticky_ovf), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", DW'(in_ready), DW'(1));

    // 32-bit signed add at the positive limit, saturate then wrap.
    send({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 1, 1, 0, 1, 2'b10,
         {4{32'h7FFF_FFFF}}, 16'hFFFF);
    drain();
    check("sticky_after_ovf", DW'(sticky_ovf), DW'(1));
    send({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 1, 1, 0, 0, 2'b10,
         {4{32'h8000_0000}}, 16'hFFFF);

    // 8-bit unsigned sub, alternating underflow / no-underflow lanes (no inter-lane borrow).
    send({8{16'h1005}}, {8{16'h0510}}, 0, 0, 1, 1, 2'b00, {8{16'h0B00}}, 16'h5555);
    send({8{16'h1005}}, {8{16'h0510}}, 0, 0, 1, 0, 2'b00, {8{16'h0BF5}}, 16'h5555);

    // 16-bit mixed signedness: unsigned 0xFFFF + signed 1 saturates; 3 + (-2) = 1.
    send({4{32'h0003_FFFF}}, {4{32'hFFFE_0001}}, 0, 1, 0, 1, 2'b01,
         {4{32'h0001_7FFF}}, 16'h3333);

    // Reserved lane_mode behaves as 32-bit.
    send({4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 0, 0, 0, 0, 2'b11, '0, 16'hFFFF);
    drain();

    // Back-to-back random beats with out_ready cycling 1,0,0,1.
    pat_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      rm   = 2'($urandom_range(0, 3));
      rs0  = 1'($urandom_range(0, 1));
      rs1  = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      rsat = 1'($urandom_range(0, 1));
      model(ra, rb, rs0, rs1, rsub, rsat, rm, ed, eo);
      send(ra, rb, rs0, rs1, rsub, rsat, rm, ed, eo);
    end
    pat_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied: results are discarded.
    out_ready = 1'b0;
    send({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 1, 1, 0, 1, 2'b10,
         {4{32'h7FFF_FFFF}}, 16'hFFFF);
    send({8{16'h1005}}, {8{16'h0510}}, 0, 0, 1, 1, 2'b00, {8{16'h0B00}}, 16'h5555);
    rst = 1'b1;
    q.delete();
    #1;
    check("in_ready_in_rst", DW'(in_ready), DW'(0));
    tick();
    rst = 1'b0;
    check("flush_out_valid", DW'(out_valid), DW'(0));
    check("flush_sticky", DW'(sticky_ovf), DW'(0));
    out_ready = 1'b1;
    repeat (6) tick();
    check("flush_no_stale", DW'(out_valid), DW'(0));

    // sticky_clr coinciding with a consumed overflowing result: the result wins.
    out_ready = 1'b0;
    send({4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, 1, 1, 0, 1, 2'b10,
         {4{32'h7FFF_FFFF}}, 16'hFFFF);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("wait_out_valid", DW'(out_valid), DW'(1));
    sticky_clr = 1'b1;
    out_ready = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_vs_ovf", DW'(sticky_ovf), DW'(1));
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_idle", DW'(sticky_ovf), DW'(0));
    check("queue_empty", DW'(q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
